// File: rtl/joy_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : joy_bus_if
//  Description : Bundles the 68020 bus strobes, the shadow-register update
//                port and the intercept outputs used by joy_bus_ctrl.
//                slave  - the controller (inputs: CPU strobes, address, punt,
//                         update request; outputs: data, claims, ack, busy)
//                master - the environment driving the CPU side and update
//                         request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface joy_bus_if;
   logic        AS20;      // address strobe, active low
   logic        DS20;      // data strobe, active low
   logic        RW;        // 1 = read
   logic [23:0] A;         // CPU address
   logic        PUNT_IN;   // accelerator punt, active low
   logic        UPD_REQ;   // shadow-register write request
   logic [1:0]  UPD_IDX;
   logic [15:0] UPD_DATA;
   logic        UPD_ACK;   // one-cycle pulse: update written
   logic [7:0]  D_OUT;     // read data for D[31:24]
   logic        D_OE;      // drive D[31:24]
   logic        PUNT_N;    // intercept claim, active low
   logic [1:0]  DSACK_N;   // cycle termination, active low
   logic        BUSY;      // controller not in IDLE

   modport slave (
      input  AS20, DS20, RW, A, PUNT_IN, UPD_REQ, UPD_IDX, UPD_DATA,
      output UPD_ACK, D_OUT, D_OE, PUNT_N, DSACK_N, BUSY
   );

   modport master (
      output AS20, DS20, RW, A, PUNT_IN, UPD_REQ, UPD_IDX, UPD_DATA,
      input  UPD_ACK, D_OUT, D_OE, PUNT_N, DSACK_N, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/joy_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : joy_bus_ctrl
//  Description : Intercepts 68020 byte reads of JOY0DAT/JOY1DAT/POT0DAT/POTINP
//                and answers them from four 16-bit shadow registers that are
//                written from the SPI side. An even-byte read snapshots the
//                low byte so the following odd-byte read of the same register
//                returns a coherent 16-bit value.
//  Ports       : CLKCPU_A - clock (rising edge)
//                RESET    - synchronous, active-high reset
//                bus      - joy_bus_if.slave (strobes, address, punt, update
//                           port, D_OUT/D_OE, PUNT_N, DSACK_N, BUSY)
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_bus_ctrl #(
   parameter int unsigned SETUP_CYC  = 1,   // clocks in DRIVE before DSACK (0-7)
   parameter int unsigned DS_TIMEOUT = 15   // clocks in WAIT_DS before PASS (1-255)
) (
   input  wire logic  CLKCPU_A,
   input  wire logic  RESET,
   joy_bus_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      WAIT_DS = 3'd2,
      DRIVE   = 3'd3,
      ACK     = 3'd4,
      PASS    = 3'd5
   } state_t;

   localparam logic [7:0] c_to_last    = 8'(DS_TIMEOUT - 1);
   // SETUP_CYC of 0 and 1 both leave DRIVE on the first edge.
   localparam logic [7:0] c_setup_last = 8'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);

   state_t      state_q, state_d;
   logic        as_q, as_d, ds_q, ds_d, rw_q, rw_d, punt_in_q, punt_in_d;
   logic [23:0] a_q, a_d;
   logic [15:0] shadow_q [4];
   logic [15:0] shadow_d [4];
   logic [7:0]  hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic [1:0]  hold_idx_q, hold_idx_d;
   logic        pend_q, pend_d;
   logic [1:0]  pend_idx_q, pend_idx_d;
   logic [15:0] pend_data_q, pend_data_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  d_out_q, d_out_d;
   logic        d_oe_q, d_oe_d, punt_n_q, punt_n_d, upd_ack_q, upd_ack_d;
   logic [1:0]  dsack_n_q, dsack_n_d;

   logic        w_match, w_odd, w_hit;
   logic [1:0]  w_idx;

   // Address decode on the registered bus copy.
   always_comb begin
      w_match = 1'b1;
      w_idx   = 2'd0;
      unique case (a_q[23:1])
         23'h6FF805: w_idx = 2'd0;   // 0xDFF00A/B
         23'h6FF806: w_idx = 2'd1;   // 0xDFF00C/D
         23'h6FF809: w_idx = 2'd2;   // 0xDFF012/3
         23'h6FF80B: w_idx = 2'd3;   // 0xDFF016/7
         default:    w_match = 1'b0;
      endcase
      w_odd = a_q[0];
      w_hit = !as_q && rw_q && punt_in_q && w_match;
   end

   always_comb begin
      as_d         = bus.AS20;
      ds_d         = bus.DS20;
      rw_d         = bus.RW;
      a_d          = bus.A;
      punt_in_d    = bus.PUNT_IN;
      state_d      = state_q;
      shadow_d     = shadow_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      hold_idx_d   = hold_idx_q;
      pend_d       = pend_q;
      pend_idx_d   = pend_idx_q;
      pend_data_d  = pend_data_q;
      cnt_d        = cnt_q;
      d_out_d      = d_out_q;
      d_oe_d       = d_oe_q;
      punt_n_d     = punt_n_q;
      dsack_n_d    = dsack_n_q;
      upd_ack_d    = 1'b0;

      // Update port. A request landing on the DECODE edge is parked for one
      // cycle; while parked, a still-high UPD_REQ is the same request.
      if (pend_q) begin
         shadow_d[pend_idx_q] = pend_data_q;
         upd_ack_d            = 1'b1;
         pend_d               = 1'b0;
      end else if (bus.UPD_REQ) begin
         if (state_q == DECODE) begin
            pend_d      = 1'b1;
            pend_idx_d  = bus.UPD_IDX;
            pend_data_d = bus.UPD_DATA;
         end else begin
            shadow_d[bus.UPD_IDX] = bus.UPD_DATA;
            upd_ack_d             = 1'b1;
         end
      end

      if (as_q) begin
         // Strobe negated: abandon whatever is in progress and free the bus.
         state_d   = IDLE;
         punt_n_d  = 1'b1;
         d_oe_d    = 1'b0;
         dsack_n_d = 2'b11;
      end else begin
         unique case (state_q)
            IDLE: state_d = DECODE;
            DECODE: begin
               if (w_hit) begin
                  if (!w_odd) begin
                     d_out_d      = shadow_q[w_idx][15:8];
                     hold_d       = shadow_q[w_idx][7:0];
                     hold_valid_d = 1'b1;
                     hold_idx_d   = w_idx;
                  end else if (hold_valid_q && (hold_idx_q == w_idx)) begin
                     d_out_d      = hold_q;
                     hold_valid_d = 1'b0;
                  end else begin
                     d_out_d      = shadow_q[w_idx][7:0];
                     hold_valid_d = 1'b0;
                  end
                  punt_n_d = 1'b0;
                  cnt_d    = 8'd0;
                  state_d  = WAIT_DS;
               end else begin
                  punt_n_d  = 1'b1;
                  d_oe_d    = 1'b0;
                  dsack_n_d = 2'b11;
                  state_d   = PASS;
               end
            end
            WAIT_DS: begin
               if (!ds_q) begin
                  d_oe_d  = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = DRIVE;
               end else if (cnt_q == c_to_last) begin
                  punt_n_d = 1'b1;
                  state_d  = PASS;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            DRIVE: begin
               if (cnt_q == c_setup_last) begin
                  dsack_n_d = 2'b10;
                  state_d   = ACK;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ACK: begin
               d_oe_d    = 1'b1;
               punt_n_d  = 1'b0;
               dsack_n_d = 2'b10;
            end
            PASS: begin
               punt_n_d  = 1'b1;
               d_oe_d    = 1'b0;
               dsack_n_d = 2'b11;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLKCPU_A) begin
      if (RESET) begin
         state_q      <= IDLE;
         as_q         <= 1'b1;
         ds_q         <= 1'b1;
         rw_q         <= 1'b0;
         a_q          <= 24'd0;
         punt_in_q    <= 1'b1;
         shadow_q     <= '{default: 16'h0000};
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
         hold_idx_q   <= 2'd0;
         pend_q       <= 1'b0;
         pend_idx_q   <= 2'd0;
         pend_data_q  <= 16'h0000;
         cnt_q        <= 8'd0;
         d_out_q      <= 8'h00;
         d_oe_q       <= 1'b0;
         punt_n_q     <= 1'b1;
         dsack_n_q    <= 2'b11;
         upd_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         as_q         <= as_d;
         ds_q         <= ds_d;
         rw_q         <= rw_d;
         a_q          <= a_d;
         punt_in_q    <= punt_in_d;
         shadow_q     <= shadow_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_idx_q   <= hold_idx_d;
         pend_q       <= pend_d;
         pend_idx_q   <= pend_idx_d;
         pend_data_q  <= pend_data_d;
         cnt_q        <= cnt_d;
         d_out_q      <= d_out_d;
         d_oe_q       <= d_oe_d;
         punt_n_q     <= punt_n_d;
         dsack_n_q    <= dsack_n_d;
         upd_ack_q    <= upd_ack_d;
      end
   end

   assign bus.D_OUT   = d_out_q;
   assign bus.D_OE    = d_oe_q;
   assign bus.PUNT_N  = punt_n_q;
   assign bus.DSACK_N = dsack_n_q;
   assign bus.UPD_ACK = upd_ack_q;
   assign bus.BUSY    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_joy_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joy_bus_ctrl
//  Description : Directed, table-driven bench for joy_bus_ctrl: a vector table
//                of {optional update, read cycle, expected result} plus
//                hand-written timeout, collision, abort and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_bus_ctrl;

   logic clk = 1'b0;
   logic rst;
   joy_bus_if bus ();

   joy_bus_ctrl dut (
      .CLKCPU_A (clk),
      .RESET    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        upd_en;
      logic [1:0]  upd_idx;
      logic [15:0] upd_data;
      logic [23:0] addr;
      logic        rw;
      logic        punt_in;
      logic        exp_hit;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [14];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // {PUNT_N, D_OE, DSACK_N, BUSY}
   function automatic logic [15:0] bus_state();
      return {11'd0, bus.PUNT_N, bus.D_OE, bus.DSACK_N, bus.BUSY};
   endfunction

   task automatic do_upd(input logic [1:0] idx, input logic [15:0] data, input string tag);
      bus.UPD_IDX  = idx;
      bus.UPD_DATA = data;
      bus.UPD_REQ  = 1'b1;
      tick();
      bus.UPD_REQ  = 1'b0;
      check({tag, " upd_ack"}, {15'd0, bus.UPD_ACK}, 16'd1);
      tick();
      check({tag, " upd_ack_end"}, {15'd0, bus.UPD_ACK}, 16'd0);
   endtask

   task automatic release_bus(input string tag);
      bus.AS20 = 1'b1;
      bus.DS20 = 1'b1;
      tick();
      tick();
      check({tag, " released"}, bus_state(), 16'b10110);
   endtask

   // Full read cycle with DS20 asserted together with AS20.
   task automatic run_read(input logic [23:0] addr, input logic rw, input logic punt,
                           input logic hit, input logic [7:0] data, input string tag);
      bus.A       = addr;
      bus.RW      = rw;
      bus.PUNT_IN = punt;
      bus.AS20    = 1'b0;
      bus.DS20    = 1'b0;
      if (hit) begin
         tick(); tick(); tick();
         check({tag, " claim"}, bus_state(), 16'b00111);
         check({tag, " d_out"}, {8'd0, bus.D_OUT}, {8'd0, data});
         tick();
         check({tag, " drive"}, bus_state(), 16'b01111);
         tick();
         check({tag, " dsack"}, bus_state(), 16'b01101);
      end else begin
         for (int i = 0; i < 5; i++) begin
            tick();
            check({tag, " no_claim"}, {12'd0, bus.PUNT_N, bus.D_OE, bus.DSACK_N}, 16'b1011);
         end
         check({tag, " pass_busy"}, {15'd0, bus.BUSY}, 16'd1);
      end
      release_bus(tag);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 2'd1, 16'h1234, 24'hDFF00D, 1'b1, 1'b1, 1'b1, 8'h34};
      vecs[1]  = '{1'b0, 2'd0, 16'h0000, 24'hDFF00C, 1'b1, 1'b1, 1'b1, 8'h12};
      vecs[2]  = '{1'b1, 2'd0, 16'hAB12, 24'hDFF00A, 1'b1, 1'b1, 1'b1, 8'hAB};
      vecs[3]  = '{1'b1, 2'd0, 16'hCD56, 24'hDFF00B, 1'b1, 1'b1, 1'b1, 8'h12};
      vecs[4]  = '{1'b0, 2'd0, 16'h0000, 24'hDFF00B, 1'b1, 1'b1, 1'b1, 8'h56};
      vecs[5]  = '{1'b1, 2'd2, 16'hBEEF, 24'hDFF013, 1'b1, 1'b1, 1'b1, 8'hEF};
      vecs[6]  = '{1'b0, 2'd0, 16'h0000, 24'hDFF012, 1'b1, 1'b1, 1'b1, 8'hBE};
      vecs[7]  = '{1'b1, 2'd3, 16'h9C3E, 24'hDFF017, 1'b1, 1'b1, 1'b1, 8'h3E};
      vecs[8]  = '{1'b0, 2'd0, 16'h0000, 24'hDFF016, 1'b1, 1'b1, 1'b1, 8'h9C};
      vecs[9]  = '{1'b1, 2'd3, 16'h0000, 24'hDFF017, 1'b1, 1'b1, 1'b1, 8'h3E};
      vecs[10] = '{1'b0, 2'd0, 16'h0000, 24'hDFF010, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[11] = '{1'b0, 2'd0, 16'h0000, 24'hDFF00A, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[12] = '{1'b0, 2'd0, 16'h0000, 24'hDFF00A, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[13] = '{1'b0, 2'd0, 16'h0000, 24'hDFF00F, 1'b1, 1'b1, 1'b0, 8'h00};

      rst          = 1'b1;
      bus.AS20     = 1'b1;
      bus.DS20     = 1'b1;
      bus.RW       = 1'b1;
      bus.A        = 24'd0;
      bus.PUNT_IN  = 1'b1;
      bus.UPD_REQ  = 1'b0;
      bus.UPD_IDX  = 2'd0;
      bus.UPD_DATA = 16'h0000;
      tick(); tick();
      check("reset bus", bus_state(), 16'b10110);
      check("reset d_out", {8'd0, bus.D_OUT}, 16'h0000);
      check("reset upd_ack", {15'd0, bus.UPD_ACK}, 16'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 14; v++) begin
         if (vecs[v].upd_en)
            do_upd(vecs[v].upd_idx, vecs[v].upd_data, $sformatf("vec%0d", v));
         run_read(vecs[v].addr, vecs[v].rw, vecs[v].punt_in, vecs[v].exp_hit,
                  vecs[v].exp_data, $sformatf("vec%0d", v));
      end

      // Timeout: hit with DS20 held high for 20 clocks.
      bus.A = 24'hDFF00D; bus.RW = 1'b1; bus.PUNT_IN = 1'b1;
      bus.AS20 = 1'b0; bus.DS20 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i >= 3)
            check($sformatf("timeout clk%0d", i),
                  {12'd0, bus.PUNT_N, bus.D_OE, bus.DSACK_N},
                  (i < 18) ? 16'b0011 : 16'b1011);
      end
      check("timeout busy", {15'd0, bus.BUSY}, 16'd1);
      release_bus("timeout");

      // Collision: update lands in the DECODE cycle of a read of reg1.
      bus.A = 24'hDFF00C; bus.RW = 1'b1; bus.PUNT_IN = 1'b1;
      bus.AS20 = 1'b0; bus.DS20 = 1'b0;
      tick(); tick();
      bus.UPD_IDX = 2'd1; bus.UPD_DATA = 16'hFFFF; bus.UPD_REQ = 1'b1;
      tick();
      bus.UPD_REQ = 1'b0;
      check("collide ack_deferred", {15'd0, bus.UPD_ACK}, 16'd0);
      check("collide d_out", {8'd0, bus.D_OUT}, 16'h0012);
      tick();
      check("collide ack_late", {15'd0, bus.UPD_ACK}, 16'd1);
      check("collide d_out_kept", {8'd0, bus.D_OUT}, 16'h0012);
      tick();
      check("collide ack_end", {15'd0, bus.UPD_ACK}, 16'd0);
      check("collide dsack", bus_state(), 16'b01101);
      release_bus("collide");
      run_read(24'hDFF00D, 1'b1, 1'b1, 1'b1, 8'h34, "collide hold");
      run_read(24'hDFF00D, 1'b1, 1'b1, 1'b1, 8'hFF, "collide new");

      // Abort: AS20 negated while waiting for DS20.
      bus.A = 24'hDFF00A; bus.AS20 = 1'b0; bus.DS20 = 1'b1;
      tick(); tick(); tick();
      check("abort wait_ds", bus_state(), 16'b00111);
      bus.AS20 = 1'b1;
      tick();
      check("abort lag", {15'd0, bus.PUNT_N}, 16'd0);
      tick();
      check("abort idle", bus_state(), 16'b10110);

      // Reset during ACK, with an update request on the reset edge.
      bus.A = 24'hDFF00A; bus.AS20 = 1'b0; bus.DS20 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rst_ack dsack", bus_state(), 16'b01101);
      rst = 1'b1; bus.AS20 = 1'b1; bus.DS20 = 1'b1;
      bus.UPD_IDX = 2'd1; bus.UPD_DATA = 16'hAAAA; bus.UPD_REQ = 1'b1;
      tick();
      check("rst_ack bus", bus_state(), 16'b10110);
      check("rst_ack d_out", {8'd0, bus.D_OUT}, 16'h0000);
      rst = 1'b0; bus.UPD_REQ = 1'b0;
      tick();
      check("rst_ack no_upd_ack", {15'd0, bus.UPD_ACK}, 16'd0);
      run_read(24'hDFF00D, 1'b1, 1'b1, 1'b1, 8'h00, "rst_ack shadow");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
